// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 10;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // The slave is chosen by the top address bit.
    function automatic int slave_sel_bit(input int addr_width);
        return addr_width - 1;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Slave decode: one-hot select from the address MSB, plus PREADY/PRDATA muxes.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  pready_s1,
    input  logic                  pready_s2,
    input  logic [DATA_WIDTH-1:0] prdata_s1,
    input  logic [DATA_WIDTH-1:0] prdata_s2,
    output logic [1:0]            sel,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int SEL_BIT = slave_sel_bit(ADDR_WIDTH);

    logic hi;

    assign hi     = addr[SEL_BIT];
    assign sel    = hi ? 2'b10 : 2'b01;
    assign pready = hi ? pready_s2 : pready_s1;
    assign prdata = hi ? prdata_s2 : prdata_s1;

endmodule

// File: rtl/apb_master_bridge.sv
// Single-command APB requester: IDLE -> SETUP -> ACCESS with wait states.
// Optional ACCESS timeout when APB_TIMEOUT_EN is defined.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL_S1,
    output logic                  PSEL_S2,
    output logic                  PENABLE_S,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] PADDR_S,
    output logic [DATA_WIDTH-1:0] PWDATA_S,
    input  logic [DATA_WIDTH-1:0] PRDATA_S1,
    input  logic [DATA_WIDTH-1:0] PRDATA_S2,
    input  logic                  PREADY_S1,
    input  logic                  PREADY_S2
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic                  accept;
    logic                  done;
    logic                  tmo_hit;
    logic                  busy;
    logic [1:0]            sel;
    logic                  pready_sel;
    logic [DATA_WIDTH-1:0] prdata_sel;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dec (
        .addr      (addr_q),
        .pready_s1 (PREADY_S1),
        .pready_s2 (PREADY_S2),
        .prdata_s1 (PRDATA_S1),
        .prdata_s2 (PRDATA_S2),
        .sel       (sel),
        .pready    (pready_sel),
        .prdata    (prdata_sel)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY takes priority over a simultaneous timeout.
                if (pready_sel) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            write_q <= cmd_write;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done | tmo_hit;
            if (done) begin
                rsp_rdata_q <= write_q ? '0 : prdata_sel;
            end else if (tmo_hit) begin
                rsp_rdata_q <= '0;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W     = (TMO_W_RAW < 8) ? 8 : TMO_W_RAW;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             rsp_err_q;

    // Fires on the edge where the wait count would reach the limit.
    assign tmo_hit = (state_q == ACCESS) && !pready_sel
                     && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS && !pready_sel) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= tmo_hit;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign cmd_ready = (state_q == IDLE);
    assign PSEL_S1   = busy & sel[0];
    assign PSEL_S2   = busy & sel[1];
    assign PENABLE_S = (state_q == ACCESS);
    assign read      = busy & ~write_q;
    assign write     = busy & write_q;
    assign PADDR_S   = addr_q;
    assign PWDATA_S  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model plus directed transfers.
// Timeout cases only run when APB_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    localparam int AW = 10;
    localparam int DW = 32;
`ifdef APB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif
    localparam int WS3 = (TMO > 6) ? 5 : 3;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL_S1, PSEL_S2, PENABLE_S, read, write;
    logic [AW-1:0] PADDR_S;
    logic [DW-1:0] PWDATA_S;
    logic [DW-1:0] PRDATA_S1 = 32'hBAD1BAD1;
    logic [DW-1:0] PRDATA_S2 = 32'h00000010;
    logic          PREADY_S1 = 1'b0;
    logic          PREADY_S2 = 1'b0;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL_S1   (PSEL_S1),
        .PSEL_S2   (PSEL_S2),
        .PENABLE_S (PENABLE_S),
        .read      (read),
        .write     (write),
        .PADDR_S   (PADDR_S),
        .PWDATA_S  (PWDATA_S),
        .PRDATA_S1 (PRDATA_S1),
        .PRDATA_S2 (PRDATA_S2),
        .PREADY_S1 (PREADY_S1),
        .PREADY_S2 (PREADY_S2)
    );

    always #5 PCLK = ~PCLK;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction model: a command occupies the bus from the cycle after it
    // is accepted; the first busy cycle is setup, later ones are access.
    bit            m_busy = 1'b0;
    int            m_age = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_write = 1'b0;
    bit            m_rsp = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_hi;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_busy = 1'b0; m_rsp = 1'b0; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            m_rsp = 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1'b1; m_age = 1;
                    m_addr = cmd_addr; m_wdata = cmd_wdata; m_write = cmd_write;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else begin
                m_hi = m_addr[AW-1];
                if (m_hi ? PREADY_S2 : PREADY_S1) begin
                    m_busy  = 1'b0;
                    m_rsp   = 1'b1;
                    m_rdata = m_write ? '0 : (m_hi ? PRDATA_S2 : PRDATA_S1);
                end
            end
        end
    end

    always @(negedge PCLK) begin
        if (chk_en) begin
            check("cmd_ready", cmd_ready, !m_busy);
            check("PSEL_S1", PSEL_S1, m_busy && !m_addr[AW-1]);
            check("PSEL_S2", PSEL_S2, m_busy && m_addr[AW-1]);
            check("PENABLE_S", PENABLE_S, m_busy && m_age == 2);
            check("read", read, m_busy && !m_write);
            check("write", write, m_busy && m_write);
            check("PADDR_S", PADDR_S, m_addr);
            check("PWDATA_S", PWDATA_S, m_wdata);
            check("rsp_valid", rsp_valid, m_rsp);
            check("rsp_err", rsp_err, 1'b0);
            if (m_rsp || !PRESETn) check("rsp_rdata", rsp_rdata, m_rdata);
        end
    end

    task automatic do_xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, output int lat, output int en_cnt,
                           output logic [DW-1:0] rd, output bit er,
                           output logic [1:0] s_psel, output logic [1:0] s_rw, output bit s_en);
        int guard;
        bit hi;
        hi = a[AW-1];
        lat = -1; en_cnt = 0; rd = '0; er = 1'b0;
        s_psel = '0; s_rw = '0; s_en = 1'b0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        PREADY_S1 = hi; PREADY_S2 = !hi;
        guard = 0;
        @(negedge PCLK);
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        if (!cmd_ready) check("accept_wait", cmd_ready, 1'b1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (hi) PREADY_S2 = (waits >= 0) && (c >= 2 + waits);
            else    PREADY_S1 = (waits >= 0) && (c >= 2 + waits);
            @(negedge PCLK);
            if (c == 1) begin
                s_psel = {PSEL_S2, PSEL_S1};
                s_rw   = {read, write};
                s_en   = PENABLE_S;
            end
            if (PENABLE_S) en_cnt++;
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
            @(posedge PCLK); #1;
        end
        PREADY_S1 = 1'b0; PREADY_S2 = 1'b0;
    endtask

    int            lat, en_cnt, rsp_cnt, guard;
    logic [DW-1:0] rd;
    bit            er, s_en;
    logic [1:0]    s_psel, s_rw;

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        PRESETn = 1'b1;

        do_xfer(1'b1, 10'h001, 32'hDEADBEEF, 0, lat, en_cnt, rd, er, s_psel, s_rw, s_en);
        check("wr_latency", lat, 3);
        check("wr_setup_psel", s_psel, 2'b01);
        check("wr_setup_rw", s_rw, 2'b01);
        check("wr_setup_penable", s_en, 1'b0);
        check("wr_penable_cycles", en_cnt, 1);
        check("wr_rdata", rd, 32'h0);

        do_xfer(1'b0, 10'h200, 32'h12345678, 3, lat, en_cnt, rd, er, s_psel, s_rw, s_en);
        check("rd_latency", lat, 6);
        check("rd_setup_psel", s_psel, 2'b10);
        check("rd_setup_rw", s_rw, 2'b10);
        check("rd_penable_cycles", en_cnt, 4);
        check("rd_rdata", rd, 32'h00000010);

        // Slave 2 is ready throughout; only slave 1 may complete this read.
        do_xfer(1'b0, 10'h000, 32'h0, WS3, lat, en_cnt, rd, er, s_psel, s_rw, s_en);
        check("wrong_ready_latency", lat, 3 + WS3);
        check("wrong_ready_rdata", rd, 32'hBAD1BAD1);

        // Requester never drops cmd_valid; address and data change every cycle.
        rsp_cnt = 0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cmd_addr  = {i[0], 9'(i * 7)};
            cmd_wdata = $urandom;
            cmd_write = i[1];
            PREADY_S1 = (i % 3) != 0;
            PREADY_S2 = i[0];
            PRDATA_S1 = $urandom;
            PRDATA_S2 = $urandom;
            @(negedge PCLK);
            if (rsp_valid) rsp_cnt++;
            @(posedge PCLK); #1;
        end
        cmd_valid = 1'b0; PREADY_S1 = 1'b1; PREADY_S2 = 1'b1;
        guard = 0;
        @(negedge PCLK);
        while (!cmd_ready && guard < 20) begin
            @(negedge PCLK);
            guard++;
        end
        check("b2b_drain", cmd_ready, 1'b1);
        check("b2b_progress", rsp_cnt >= 5, 1'b1);
        PREADY_S1 = 1'b0; PREADY_S2 = 1'b0;
        PRDATA_S1 = 32'hBAD1BAD1; PRDATA_S2 = 32'h00000010;

        // Reset during an access wait state.
        @(posedge PCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h200; PREADY_S1 = 1'b1;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge PCLK);
        #3;
        check("pre_reset_penable", PENABLE_S, 1'b1);
        PRESETn = 1'b0;
        #1;
        check("rst_psel2", PSEL_S2, 1'b0);
        check("rst_penable", PENABLE_S, 1'b0);
        check("rst_read", read, 1'b0);
        check("rst_paddr", PADDR_S, 10'h000);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        PREADY_S2 = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        rsp_cnt = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (rsp_valid) rsp_cnt++;
        end
        check("rst_no_rsp", rsp_cnt, 0);
        PREADY_S1 = 1'b0; PREADY_S2 = 1'b0;

        do_xfer(1'b1, 10'h3FF, 32'hCAFEF00D, 1, lat, en_cnt, rd, er, s_psel, s_rw, s_en);
        check("post_rst_latency", lat, 4);
        check("post_rst_rdata", rd, 32'h0);

`ifdef APB_TIMEOUT_EN
        chk_en = 1'b0;
        do_xfer(1'b0, 10'h000, 32'h0, -1, lat, en_cnt, rd, er, s_psel, s_rw, s_en);
        check("tmo_latency", lat, 6);
        check("tmo_err", er, 1'b1);
        check("tmo_rdata", rd, 32'h0);
        check("tmo_penable_cycles", en_cnt, 4);
        do_xfer(1'b0, 10'h000, 32'h0, 3, lat, en_cnt, rd, er, s_psel, s_rw, s_en);
        check("tmo_race_latency", lat, 6);
        check("tmo_race_err", er, 1'b0);
        check("tmo_race_rdata", rd, 32'hBAD1BAD1);
`endif

        repeat (2) @(posedge PCLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
